reg_chain_master: RTL and testbench
===================================

// Module: reg_chain_master
// PURPOSE
//  Initiator for the triplicated serial-load configuration registers: turns parallel host
//  write/read/pulse requests into the shiftEn/shiftIn/latchIn/latchOut/clkEn/pulseRst sequence
//  and reassembles read data from the register shift-out line. One instance sits between the
//  command decoder and a bank of NREGS registers. It also holds a sticky soft-error flag driven
//  by the end of the serOut chain.
// PARAMETERS
//  NREGS  8   number of registers in the bank, selected by address
//  AW     3   address width; 2**AW >= NREGS
//  WIDTH  32  register/shifter width; fixed at 32 for this bank
// PORTS
//  bclk           in   1      clock; the register bank uses the same clock
//  rst            in   1      synchronous reset, active-high
//  req_valid      in   1      host request valid
//  req_ready      out  1      high only in IDLE; accept = req_valid & req_ready
//  req_op         in   2      00 write, 01 read, 10 pulse-reset, 11 reserved
//  req_addr       in   AW     target register index
//  req_wdata      in   WIDTH  write data, shifted out MSB first
//  done           out  1      one-cycle completion pulse
//  done_err       out  1      valid with done: bad address or reserved op
//  rd_data        out  WIDTH  read result; valid at done, held until the next accepted read
//  clk_en         out  NREGS  one-hot clkEn to the selected register for the whole op
//  shift_en       out  NREGS  one-hot shiftEn; unselected registers therefore drive shiftOut=0
//  reg_shift_in   out  1      serial data to the shared shiftIn of all registers
//  reg_shift_out  in   1      OR of all registers' shiftOut lines
//  latch_in       out  1      broadcast latchIn; only the clk_en-selected register acts on it
//  latch_out      out  1      broadcast latchOut
//  pulse_rst      out  NREGS  one-hot pulseRst, one cycle
//  ser_in         in   1      serOut from the end of the register chain
//  clear_err      in   1      clears ser_err
//  ser_err        out  1      sticky soft-error flag
// BEHAVIOUR
//  - All outputs are registered. Reset values: every output is 0, state = IDLE, and req_ready
//    is 0 in the reset cycle and 1 from the following cycle. rst takes priority over all events.
//  - States: IDLE, LATCHO, SHIFT, LATCHI, PULSE, DONE. A 6-bit counter cnt runs 0..31 in SHIFT.
//  - Write (accept at cycle 0):
//    - SHIFT in cycles 1..32: clk_en[a]=1, shift_en[a]=1, reg_shift_in = wdata[31-cnt].
//    - LATCHI in cycle 33: latch_in=1, shift_en=0, clk_en[a]=1.
//    - DONE in cycle 34: done=1, then IDLE.
//  - Read:
//    - LATCHO in cycle 1: latch_out=1, clk_en[a]=1.
//    - SHIFT in cycles 2..33: reg_shift_in=0. At each SHIFT edge, rd_data <= {rd_data[30:0], reg_shift_out}.
//    - DONE in cycle 34: done=1 and rd_data equals the register value.
//  - Pulse: PULSE in cycle 1 with pulse_rst[a]=1 and clk_en=0; DONE in cycle 2.
//  - Bad address (req_addr >= NREGS) or op 11: the request is accepted and goes straight to DONE
//    in cycle 1 with done=1 and done_err=1. No clk_en, shift_en or pulse_rst is asserted and
//    rd_data is unchanged.
//  - done_err=0 on every good completion. done is never asserted outside the DONE state.
//  - req_* are sampled only at accept; changes during an op are ignored. No request is accepted
//    in the DONE cycle.
//  - Outside SHIFT, reg_shift_in=0. latch_in and latch_out are never high together, and neither
//    is high while any shift_en is high.
//  - ser_err: set whenever ser_in=1, cleared by clear_err. Set wins when both happen in the same
//    cycle. The flag is independent of the state machine.
//  - Reset mid-op: return to IDLE with outputs 0. A write aborted before LATCHI leaves the
//    register state untouched; only its shifter is disturbed.
// STRUCTURE
//  - Shared package reg_chain_pkg:
//    - op encodings OP_WR, OP_RD, OP_PULSE, OP_RSVD
//    - state enum
//    - SHIFT_LEN=32
//  - One sub-module, reg_chain_shifter: a 32-bit register with parallel load of req_wdata,
//    MSB-first serial output, and serial capture from reg_shift_out. The FSM and decoders stay
//    at top level.
// TESTING
//  - Write 0xA5C3_0F81 to addr 2, then read it back with a bench model of reg32tz on each
//    address -> rd_data=0xA5C3_0F81, done_err=0, done exactly 34 cycles after accept for both ops.
//  - During the write: shift_en==8'b0000_0100 for exactly 32 cycles, then a single latch_in
//    cycle; other registers' dataOut are unchanged.
//  - Pulse on addr 5 with the register at 0xFFFF_FFFF -> pulse_rst==8'b0010_0000 for one cycle;
//    register reads back 0xFFFF_FFF0.
//  - req_addr=7 with NREGS=6 and op 11 -> done and done_err in cycle 1; no strobes; rd_data unchanged.
//  - Assert rst at write cycle 20 -> all outputs 0 the next cycle; register still reads its old value.
//  - Pulse ser_in for 1 cycle -> ser_err=1 and sticky; clear_err together with ser_in -> stays 1;
//    clear_err alone -> 0.

Source files
------------

// File: rtl/reg_chain_pkg.sv
// Shared encodings for the serial-load configuration register initiator.
// Imported by reg_chain_master and reg_chain_shifter.
package reg_chain_pkg;

    localparam int unsigned SHIFT_LEN = 32;

    localparam logic [1:0] OP_WR    = 2'b00;
    localparam logic [1:0] OP_RD    = 2'b01;
    localparam logic [1:0] OP_PULSE = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StLatchO,
        StShift,
        StLatchI,
        StPulse,
        StDone
    } state_e;

endpackage

// File: rtl/reg_chain_shifter.sv
// Serialiser/deserialiser: parallel load, MSB-first serial out and serial capture.
// The load drops the MSB because the caller puts it on the registered line directly.
module reg_chain_shifter
    import reg_chain_pkg::*;
#(
    parameter int unsigned WIDTH = SHIFT_LEN
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             shift_i,
    input  logic             ser_i,
    output logic             ser_o,
    output logic [WIDTH-1:0] cap_o
);

    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_d;

    always_comb begin
        sh_d = sh_q;
        if (load_i) begin
            sh_d = {data_i[WIDTH-2:0], 1'b0};
        end else if (shift_i) begin
            sh_d = {sh_q[WIDTH-2:0], ser_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign ser_o = sh_q[WIDTH-1];
    // Value the shifter will hold once the current serial bit is captured.
    assign cap_o = {sh_q[WIDTH-2:0], ser_i};

endmodule

// File: rtl/reg_chain_master.sv
// Host-side initiator for the triplicated serial-load register bank: sequences
// shift/latch/pulse strobes and reassembles read data from the shared shift-out line.
module reg_chain_master
    import reg_chain_pkg::*;
#(
    parameter int unsigned NREGS = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned WIDTH = SHIFT_LEN
) (
    input  logic             bclk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [AW-1:0]    req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             done,
    output logic             done_err,
    output logic [WIDTH-1:0] rd_data,
    output logic [NREGS-1:0] clk_en,
    output logic [NREGS-1:0] shift_en,
    output logic             reg_shift_in,
    input  logic             reg_shift_out,
    output logic             latch_in,
    output logic             latch_out,
    output logic [NREGS-1:0] pulse_rst,
    input  logic             ser_in,
    input  logic             clear_err,
    output logic             ser_err
);

    localparam logic [5:0] CntLast = 6'(SHIFT_LEN - 1);

    state_e         state_q, state_d;
    logic [5:0]     cnt_q, cnt_d;
    logic [1:0]     op_q, op_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           err_q, err_d;

    logic             req_ready_q, req_ready_d;
    logic             done_q, done_d;
    logic             done_err_q, done_err_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic [NREGS-1:0] clk_en_q, clk_en_d;
    logic [NREGS-1:0] shift_en_q, shift_en_d;
    logic [NREGS-1:0] pulse_rst_q, pulse_rst_d;
    logic             rsi_q, rsi_d;
    logic             latch_in_q, latch_in_d;
    logic             latch_out_q, latch_out_d;
    logic             ser_err_q, ser_err_d;

    logic             accept;
    logic             req_bad;
    logic [NREGS-1:0] sel_d;
    logic             shf_load;
    logic             shf_shift;
    logic             shf_ser;
    logic [WIDTH-1:0] shf_cap;

    assign accept  = req_valid & req_ready_q;
    assign req_bad = (32'(req_addr) >= NREGS) || (req_op == OP_RSVD);

    reg_chain_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .clk_i   (bclk),
        .rst_i   (rst),
        .load_i  (shf_load),
        .data_i  (req_wdata),
        .shift_i (shf_shift),
        .ser_i   (reg_shift_out),
        .ser_o   (shf_ser),
        .cap_o   (shf_cap)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        addr_d    = addr_q;
        err_d     = err_q;
        shf_load  = 1'b0;
        shf_shift = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d   = req_op;
                    addr_d = req_addr;
                    cnt_d  = '0;
                    err_d  = req_bad;
                    if (req_bad) begin
                        state_d = StDone;
                    end else begin
                        unique case (req_op)
                            OP_WR: begin
                                state_d  = StShift;
                                shf_load = 1'b1;
                            end
                            OP_RD:    state_d = StLatchO;
                            OP_PULSE: state_d = StPulse;
                            default:  state_d = StDone;
                        endcase
                    end
                end
            end
            StLatchO: state_d = StShift;
            StShift: begin
                shf_shift = 1'b1;
                if (cnt_q == CntLast) begin
                    state_d = (op_q == OP_WR) ? StLatchI : StDone;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            StLatchI: state_d = StDone;
            StPulse:  state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight off a flop.
    always_comb begin
        sel_d       = NREGS'(1) << addr_d;
        req_ready_d = (state_d == StIdle);
        clk_en_d    = '0;
        shift_en_d  = '0;
        pulse_rst_d = '0;
        latch_in_d  = (state_d == StLatchI);
        latch_out_d = (state_d == StLatchO);
        done_d      = (state_d == StDone);
        done_err_d  = (state_d == StDone) && err_d;
        rsi_d       = 1'b0;
        rd_data_d   = rd_data_q;
        ser_err_d   = ser_in ? 1'b1 : (clear_err ? 1'b0 : ser_err_q);

        if (state_d == StLatchO || state_d == StShift || state_d == StLatchI) begin
            clk_en_d = sel_d;
        end
        if (state_d == StShift) begin
            shift_en_d = sel_d;
            if (op_d == OP_WR) begin
                rsi_d = (state_q == StIdle) ? req_wdata[WIDTH-1] : shf_ser;
            end
        end
        if (state_d == StPulse) begin
            pulse_rst_d = sel_d;
        end
        if (state_q == StShift && op_q == OP_RD) begin
            rd_data_d = shf_cap;
        end
    end

    always_ff @(posedge bclk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            op_q        <= OP_WR;
            addr_q      <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b0;
            done_q      <= 1'b0;
            done_err_q  <= 1'b0;
            rd_data_q   <= '0;
            clk_en_q    <= '0;
            shift_en_q  <= '0;
            pulse_rst_q <= '0;
            rsi_q       <= 1'b0;
            latch_in_q  <= 1'b0;
            latch_out_q <= 1'b0;
            ser_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
            done_q      <= done_d;
            done_err_q  <= done_err_d;
            rd_data_q   <= rd_data_d;
            clk_en_q    <= clk_en_d;
            shift_en_q  <= shift_en_d;
            pulse_rst_q <= pulse_rst_d;
            rsi_q       <= rsi_d;
            latch_in_q  <= latch_in_d;
            latch_out_q <= latch_out_d;
            ser_err_q   <= ser_err_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign done         = done_q;
    assign done_err     = done_err_q;
    assign rd_data      = rd_data_q;
    assign clk_en       = clk_en_q;
    assign shift_en     = shift_en_q;
    assign pulse_rst    = pulse_rst_q;
    assign reg_shift_in = rsi_q;
    assign latch_in     = latch_in_q;
    assign latch_out    = latch_out_q;
    assign ser_err      = ser_err_q;

endmodule

// File: tb/tb_reg_chain_master.sv
// Bench for reg_chain_master driving a behavioural six-register serial-load bank;
// completions are checked against a queue of expected responses.
module tb_reg_chain_master;

    localparam logic [1:0] OpWr = 2'b00;
    localparam logic [1:0] OpRd = 2'b01;
    localparam logic [1:0] OpPu = 2'b10;
    localparam logic [1:0] OpRs = 2'b11;

    logic        bclk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [2:0]  req_addr = 3'd0;
    logic [31:0] req_wdata = 32'h0;
    logic        done;
    logic        done_err;
    logic [31:0] rd_data;
    logic [5:0]  clk_en;
    logic [5:0]  shift_en;
    logic        reg_shift_in;
    logic        reg_shift_out;
    logic        latch_in;
    logic        latch_out;
    logic [5:0]  pulse_rst;
    logic        ser_in = 1'b0;
    logic        clear_err = 1'b0;
    logic        ser_err;

    reg_chain_master #(
        .NREGS (6),
        .AW    (3),
        .WIDTH (32)
    ) dut (
        .bclk          (bclk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .done          (done),
        .done_err      (done_err),
        .rd_data       (rd_data),
        .clk_en        (clk_en),
        .shift_en      (shift_en),
        .reg_shift_in  (reg_shift_in),
        .reg_shift_out (reg_shift_out),
        .latch_in      (latch_in),
        .latch_out     (latch_out),
        .pulse_rst     (pulse_rst),
        .ser_in        (ser_in),
        .clear_err     (clear_err),
        .ser_err       (ser_err)
    );

    always #5 bclk = ~bclk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Register bank model: reg32tz with clkEn-gated shifter and latches; pulseRst clears [3:0].
    logic [31:0] bank_do [6] = '{default: 32'h0};
    logic [31:0] bank_sh [6] = '{default: 32'h0};

    always @(posedge bclk) begin
        for (int i = 0; i < 6; i++) begin
            if (clk_en[i]) begin
                if (shift_en[i]) bank_sh[i] <= {bank_sh[i][30:0], reg_shift_in};
                if (latch_in)    bank_do[i] <= bank_sh[i];
                if (latch_out)   bank_sh[i] <= bank_do[i];
            end
            if (pulse_rst[i]) bank_do[i][3:0] <= 4'h0;
        end
    end

    always_comb begin
        reg_shift_out = 1'b0;
        for (int i = 0; i < 6; i++) begin
            reg_shift_out = reg_shift_out | (clk_en[i] & shift_en[i] & bank_sh[i][31]);
        end
    end

    typedef struct {
        logic [31:0] rd;
        logic        chk_rd;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   acc_cyc = 0;

    always @(posedge bclk) cyc <= cyc + 1;

    // Monitor: pops one expectation per done pulse; also checks per-cycle strobe invariants.
    always @(negedge bclk) begin
        exp_t e;
        if (!rst) begin
            if (req_valid && req_ready) acc_cyc = cyc;
            check("latch_exclusive", 32'(latch_in & latch_out), 32'h0);
            check("latch_vs_shift", 32'((latch_in | latch_out) & (|shift_en)), 32'h0);
            check("err_without_done", 32'(done_err & ~done), 32'h0);
            if (done) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("done_latency", 32'(cyc - acc_cyc), 32'(e.lat));
                    check("done_err", 32'(done_err), 32'(e.err));
                    if (e.chk_rd) check("rd_data", rd_data, e.rd);
                end
            end
        end
    end

    int n_se, n_se_bad, n_li, n_lo, n_pr, n_pr_bad, n_clk_pulse, n_any;

    task automatic do_op(input logic [1:0] op, input logic [2:0] addr, input logic [31:0] wd,
                         input logic chk_rd, input logic [31:0] exp_rd, input logic exp_err,
                         input int exp_lat);
        logic [5:0] oh;
        bit         seen;
        oh = 6'(1) << addr;
        sb_q.push_back('{rd: exp_rd, chk_rd: chk_rd, err: exp_err, lat: exp_lat});
        n_se = 0; n_se_bad = 0; n_li = 0; n_lo = 0;
        n_pr = 0; n_pr_bad = 0; n_clk_pulse = 0; n_any = 0;
        seen = 1'b0;
        req_op = op; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        @(negedge bclk);
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge bclk);
        check("ready_before_accept", 32'(req_ready), 32'h1);
        @(posedge bclk);
        #1;
        // Scramble the request fields; the DUT must have captured them at accept.
        req_valid = 1'b0; req_addr = addr ^ 3'b011; req_wdata = ~wd; req_op = ~op;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge bclk);
            if (shift_en == oh && oh != 0) n_se++;
            else if (shift_en != 0) n_se_bad++;
            n_li += int'(latch_in);
            n_lo += int'(latch_out);
            if (pulse_rst == oh && oh != 0) begin
                n_pr++;
                if (clk_en != 0) n_clk_pulse++;
            end else if (pulse_rst != 0) begin
                n_pr_bad++;
            end
            if ((clk_en | shift_en | pulse_rst) != 0) n_any++;
            seen = done;
        end
        check("done_seen", 32'(seen), 32'h1);
        @(posedge bclk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge bclk);
        @(negedge bclk);
        check("reset_outputs", {7'h0, clk_en, shift_en, pulse_rst, latch_in, latch_out,
                                reg_shift_in, done, done_err, req_ready, ser_err}, 32'h0);
        check("reset_rd_data", rd_data, 32'h0);
        @(posedge bclk);
        #1 rst = 1'b0;
        @(negedge bclk);
        check("ready_in_reset_cycle", 32'(req_ready), 32'h0);
        @(negedge bclk);
        check("ready_after_reset", 32'(req_ready), 32'h1);
        @(posedge bclk);
        #1;

        do_op(OpWr, 3'd5, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, 34);
        do_op(OpWr, 3'd0, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 34);
        do_op(OpWr, 3'd2, 32'hA5C3_0F81, 1'b0, 32'h0, 1'b0, 34);
        check("wr_shift_en_cycles", 32'(n_se), 32'd32);
        check("wr_shift_en_other", 32'(n_se_bad), 32'd0);
        check("wr_latch_in_cycles", 32'(n_li), 32'd1);
        check("wr_latch_out_cycles", 32'(n_lo), 32'd0);
        check("wr_strobe_cycles", 32'(n_any), 32'd33);
        check("wr_reg2_value", bank_do[2], 32'hA5C3_0F81);
        check("wr_reg0_unchanged", bank_do[0], 32'h1234_5678);
        check("wr_reg5_unchanged", bank_do[5], 32'hFFFF_FFFF);

        do_op(OpRd, 3'd2, 32'h0, 1'b1, 32'hA5C3_0F81, 1'b0, 34);
        check("rd_latch_out_cycles", 32'(n_lo), 32'd1);
        check("rd_latch_in_cycles", 32'(n_li), 32'd0);
        check("rd_shift_en_cycles", 32'(n_se), 32'd32);
        do_op(OpRd, 3'd0, 32'h0, 1'b1, 32'h1234_5678, 1'b0, 34);
        do_op(OpRd, 3'd5, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0, 34);

        do_op(OpPu, 3'd5, 32'h0, 1'b0, 32'h0, 1'b0, 2);
        check("pulse_cycles", 32'(n_pr), 32'd1);
        check("pulse_wrong_sel", 32'(n_pr_bad), 32'd0);
        check("pulse_clk_en", 32'(n_clk_pulse), 32'd0);
        check("pulse_strobe_cycles", 32'(n_any), 32'd1);
        do_op(OpRd, 3'd5, 32'h0, 1'b1, 32'hFFFF_FFF0, 1'b0, 34);

        do_op(OpWr, 3'd7, 32'hCAFE_F00D, 1'b1, 32'hFFFF_FFF0, 1'b1, 1);
        check("bad_addr_strobes", 32'(n_any), 32'd0);
        do_op(OpRs, 3'd1, 32'h0, 1'b1, 32'hFFFF_FFF0, 1'b1, 1);
        check("rsvd_op_strobes", 32'(n_any + n_li + n_lo), 32'd0);

        // Abort a write in its 20th cycle.
        req_op = OpWr; req_addr = 3'd2; req_wdata = 32'hDEAD_BEEF; req_valid = 1'b1;
        @(negedge bclk);
        check("abort_ready", 32'(req_ready), 32'h1);
        @(posedge bclk);
        #1 req_valid = 1'b0;
        repeat (19) @(posedge bclk);
        #1 rst = 1'b1;
        @(posedge bclk);
        @(negedge bclk);
        check("abort_outputs", {7'h0, clk_en, shift_en, pulse_rst, latch_in, latch_out,
                                reg_shift_in, done, done_err, req_ready, ser_err}, 32'h0);
        check("abort_rd_data", rd_data, 32'h0);
        @(posedge bclk);
        #1 rst = 1'b0;
        @(negedge bclk);
        check("abort_reg2_kept", bank_do[2], 32'hA5C3_0F81);
        do_op(OpRd, 3'd2, 32'h0, 1'b1, 32'hA5C3_0F81, 1'b0, 34);

        @(negedge bclk);
        check("ser_err_idle", 32'(ser_err), 32'h0);
        @(posedge bclk);
        #1 ser_in = 1'b1;
        @(posedge bclk);
        #1 ser_in = 1'b0;
        @(negedge bclk);
        check("ser_err_set", 32'(ser_err), 32'h1);
        @(negedge bclk);
        check("ser_err_sticky", 32'(ser_err), 32'h1);
        @(posedge bclk);
        #1 begin ser_in = 1'b1; clear_err = 1'b1; end
        @(posedge bclk);
        #1 begin ser_in = 1'b0; clear_err = 1'b0; end
        @(negedge bclk);
        check("ser_err_set_wins", 32'(ser_err), 32'h1);
        @(posedge bclk);
        #1 clear_err = 1'b1;
        @(posedge bclk);
        #1 clear_err = 1'b0;
        @(negedge bclk);
        check("ser_err_cleared", 32'(ser_err), 32'h0);

        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
